// File: rtl/conv_load_responder.sv
// conv_load_responder: reads an NxN block of words from a synchronous RAM into a flat output array
module conv_load_responder #(
  parameter int DATA_SZ   = 16,
  parameter int ADDR_SZ   = 16,
  parameter int MAX_WORDS = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      loadEnable,
  input  logic [ADDR_SZ-1:0]        loadAddr,
  input  logic [DATA_SZ-1:0]        loadSize,
  output logic signed [DATA_SZ-1:0] loadOut [0:MAX_WORDS-1],
  output logic                      loadDone,
  output logic                      busy,
  output logic                      memReadEnable,
  output logic [ADDR_SZ-1:0]        memAddr,
  input  logic [DATA_SZ-1:0]        memDataIn
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int IW = $clog2(MAX_WORDS);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d, req_cnt;
  logic [IW-1:0] cap_q, cap_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic mre_q, mre_d, vld_q, done_q, done_d, busy_q, busy_d, clr;
  logic [2*DATA_SZ-1:0] prod;
  logic signed [DATA_SZ-1:0] out_q [0:MAX_WORDS-1];
  assign prod = {{DATA_SZ{1'b0}}, loadSize} * {{DATA_SZ{1'b0}}, loadSize};
  assign req_cnt = prod > (2*DATA_SZ)'(MAX_WORDS) ? CW'(MAX_WORDS) : prod[CW-1:0];
  assign loadOut = out_q;
  assign loadDone = done_q;
  assign busy = busy_q;
  assign memReadEnable = mre_q;
  assign memAddr = addr_q;
  // next-state: issue one read per READ cycle; vld_q marks the word returning from last cycle's read
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    addr_d = '0;
    mre_d = 1'b0;
    clr = 1'b0;
    cap_d = vld_q ? cap_q + IW'(1) : cap_q;
    case (state_q)
      IDLE: if (loadEnable) begin
        cnt_d = req_cnt;
        clr = 1'b1;
        cap_d = '0;
        state_d = req_cnt == '0 ? DONE : READ;
        mre_d = req_cnt != '0;
        addr_d = req_cnt != '0 ? loadAddr : '0;
        idx_d = CW'(1);
      end
      READ: begin
        state_d = idx_q == cnt_q ? DRAIN : READ;
        mre_d = idx_q != cnt_q;
        addr_d = idx_q != cnt_q ? addr_q + ADDR_SZ'(1) : '0;
        idx_d = idx_q + CW'(1);
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  // state, registered outputs, and the output array (cleared on accept, filled from returning reads)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      cap_q <= '0;
      addr_q <= '0;
      mre_q <= 1'b0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      for (int k = 0; k < MAX_WORDS; k++) out_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cap_q <= cap_d;
      addr_q <= addr_d;
      mre_q <= mre_d;
      vld_q <= mre_q;
      done_q <= done_d;
      busy_q <= busy_d;
      if (clr) for (int k = 0; k < MAX_WORDS; k++) out_q[k] <= '0;
      else if (vld_q) out_q[cap_q] <= memDataIn;
    end
  end
endmodule

// File: tb/tb_conv_load_responder.sv
// tb_conv_load_responder: directed checks of the load responder against a RAM holding RAM[a]=a
module tb_conv_load_responder;
  logic clk = 1'b0, reset = 1'b1, loadEnable = 1'b0, loadDone, busy, memReadEnable;
  logic [15:0] loadAddr = '0, loadSize = '0, memAddr, mem_data = '0;
  logic signed [15:0] load_out [0:1023];
  int vec = 0, miscmp = 0, cyc_n = 0, done_cnt = 0, t_done = 0;
  int lat, nrd, t1, d0;
  bit aerr, mre_bad = 1'b0;

  conv_load_responder dut (
    .clk(clk), .reset(reset), .loadEnable(loadEnable), .loadAddr(loadAddr), .loadSize(loadSize),
    .loadOut(load_out), .loadDone(loadDone), .busy(busy), .memReadEnable(memReadEnable),
    .memAddr(memAddr), .memDataIn(mem_data)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, contents equal to address
  always @(posedge clk) if (memReadEnable) mem_data <= memAddr;

  always @(negedge clk) begin
    cyc_n++;
    if (loadDone) done_cnt++;
    if (memReadEnable && !busy) mre_bad = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_zero_from(input int lo);
    for (int i = lo; i < 1024; i++) if (load_out[i] !== 16'sd0) return 1'b0;
    return 1'b1;
  endfunction

  // issue one request, follow it to loadDone; leaves the bench in the DONE cycle
  task automatic run_load(input logic [15:0] a, input logic [15:0] s, input bit hold, input bit perturb);
    lat = -1;
    nrd = 0;
    aerr = 1'b0;
    loadEnable = 1'b1;
    loadAddr = a;
    loadSize = s;
    step();
    if (perturb) begin
      loadAddr = 16'h0777;
      loadSize = 16'd5;
      loadEnable = 1'b0;
    end
    for (int c = 1; c <= 1100; c++) begin
      if (memReadEnable) begin
        if (memAddr !== 16'(a + nrd)) aerr = 1'b1;
        nrd++;
      end
      if (loadDone) begin
        lat = c;
        t_done = cyc_n;
        break;
      end
      step();
    end
    if (!hold) loadEnable = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_done", {15'b0, loadDone}, 16'd0);
    chk("rst_busy", {15'b0, busy}, 16'd0);
    chk("rst_mre", {15'b0, memReadEnable}, 16'd0);
    chk("rst_addr", memAddr, 16'h0000);
    chk("rst_out_zero", {15'b0, all_zero_from(0)}, 16'd1);

    run_load(16'h0000, 16'd32, 1'b0, 1'b0);
    chk("max_lat", 16'(lat), 16'd1026);
    chk("max_reads", 16'(nrd), 16'd1024);
    chk("max_addr_seq", {15'b0, aerr}, 16'd0);
    chk("max_out1023", load_out[1023], 16'h03FF);
    chk("max_out0", load_out[0], 16'h0000);
    chk("max_out512", load_out[512], 16'h0200);
    step();

    run_load(16'h0100, 16'd3, 1'b0, 1'b0);
    chk("3x3_lat", 16'(lat), 16'd11);
    chk("3x3_reads", 16'(nrd), 16'd9);
    chk("3x3_addr_seq", {15'b0, aerr}, 16'd0);
    chk("3x3_busy_done", {15'b0, busy}, 16'd1);
    for (int i = 0; i < 9; i++) chk($sformatf("3x3_out%0d", i), load_out[i], 16'h0100 + 16'(i));
    chk("3x3_rest_zero", {15'b0, all_zero_from(9)}, 16'd1);
    step();
    chk("3x3_idle_busy", {15'b0, busy}, 16'd0);
    chk("3x3_idle_done", {15'b0, loadDone}, 16'd0);
    chk("3x3_hold_out8", load_out[8], 16'h0108);

    run_load(16'h0000, 16'd40, 1'b0, 1'b0);
    chk("over_lat", 16'(lat), 16'd1026);
    chk("over_reads", 16'(nrd), 16'd1024);
    step();

    run_load(16'hFFFE, 16'd2, 1'b0, 1'b0);
    chk("wrap_lat", 16'(lat), 16'd6);
    chk("wrap_reads", 16'(nrd), 16'd4);
    chk("wrap_addr_seq", {15'b0, aerr}, 16'd0);
    chk("wrap_out0", load_out[0], 16'hFFFE);
    chk("wrap_out1", load_out[1], 16'hFFFF);
    chk("wrap_out2", load_out[2], 16'h0000);
    chk("wrap_out3", load_out[3], 16'h0001);
    chk("wrap_rest_zero", {15'b0, all_zero_from(4)}, 16'd1);
    step();

    run_load(16'h0600, 16'd0, 1'b0, 1'b0);
    chk("zero_lat", 16'(lat), 16'd1);
    chk("zero_reads", 16'(nrd), 16'd0);
    chk("zero_out_zero", {15'b0, all_zero_from(0)}, 16'd1);
    step();

    d0 = done_cnt;
    run_load(16'h0010, 16'd5, 1'b1, 1'b0);
    chk("b2b_a_lat", 16'(lat), 16'd27);
    chk("b2b_a_reads", 16'(nrd), 16'd25);
    t1 = t_done;
    loadAddr = 16'h0200;
    loadSize = 16'd3;
    step();
    chk("b2b_idle_busy", {15'b0, busy}, 16'd0);
    chk("b2b_idle_mre", {15'b0, memReadEnable}, 16'd0);
    chk("b2b_idle_done", {15'b0, loadDone}, 16'd0);
    run_load(16'h0200, 16'd3, 1'b0, 1'b0);
    chk("b2b_b_lat", 16'(lat), 16'd11);
    chk("b2b_b_addr_seq", {15'b0, aerr}, 16'd0);
    chk("b2b_gap", 16'(t_done - t1), 16'd12);
    chk("b2b_out0", load_out[0], 16'h0200);
    chk("b2b_out8", load_out[8], 16'h0208);
    chk("b2b_out9", load_out[9], 16'h0000);
    step();
    chk("b2b_pulses", 16'(done_cnt - d0), 16'd2);

    loadEnable = 1'b1;
    loadAddr = 16'h0300;
    loadSize = 16'd4;
    step();
    step();
    step();
    step();
    chk("rmid_busy", {15'b0, busy}, 16'd1);
    chk("rmid_captured", load_out[0], 16'h0300);
    reset = 1'b1;
    loadEnable = 1'b0;
    step();
    reset = 1'b0;
    chk("rmid_done", {15'b0, loadDone}, 16'd0);
    chk("rmid_mre", {15'b0, memReadEnable}, 16'd0);
    chk("rmid_busy_after", {15'b0, busy}, 16'd0);
    chk("rmid_addr", memAddr, 16'h0000);
    chk("rmid_out_zero", {15'b0, all_zero_from(0)}, 16'd1);
    step();
    chk("rmid_discard", {15'b0, all_zero_from(0)}, 16'd1);
    run_load(16'h0400, 16'd2, 1'b0, 1'b0);
    chk("rpost_lat", 16'(lat), 16'd6);
    chk("rpost_out0", load_out[0], 16'h0400);
    chk("rpost_out3", load_out[3], 16'h0403);
    step();

    d0 = done_cnt;
    run_load(16'h0500, 16'd3, 1'b0, 1'b1);
    chk("chg_lat", 16'(lat), 16'd11);
    chk("chg_reads", 16'(nrd), 16'd9);
    chk("chg_addr_seq", {15'b0, aerr}, 16'd0);
    chk("chg_out0", load_out[0], 16'h0500);
    chk("chg_out8", load_out[8], 16'h0508);
    chk("chg_out9", load_out[9], 16'h0000);
    step();
    step();
    step();
    chk("chg_idle_busy", {15'b0, busy}, 16'd0);
    chk("chg_pulses", 16'(done_cnt - d0), 16'd1);
    chk("mre_outside_busy", {15'b0, mre_bad}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
